// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: programmable half-period SCLK, CPOL/CPHA
// modes, per-edge sample/shift strobes, start/busy/done handshake, abort.
//
// Ports:
//   clk_arr    in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   transfer request, accepted only in IDLE
//   abort      in   synchronous abort of the running transfer
//   div_half   in   SCLK half-period in clk_arr cycles (0 -> 1)
//   cpol       in   SCLK idle level
//   cpha       in   0: sample leading / shift trailing, 1: reverse
//   num_bits   in   bits per transfer (0 -> start ignored)
//   sclk       out  serial clock, straight from a flip-flop
//   sample_stb out  high in the first cycle of a sample edge level
//   shift_stb  out  high in the first cycle of a shift edge level
//   busy       out  transfer in progress
//   done       out  one-cycle pulse at normal completion
module spi_sclk_gen #(
    parameter int DIV_W  = 16,
    parameter int BITS_W = 6
) (
    input  logic              clk_arr,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DIV_W-1:0]  div_half,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [BITS_W-1:0] num_bits,
    output logic              sclk,
    output logic              sample_stb,
    output logic              shift_stb,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_GUARD = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] H_ONE  = DIV_W'(1);
    localparam logic [BITS_W:0]  E_ONE  = (BITS_W+1)'(1);

    state_t r_state;
    state_t w_state_nxt;

    // transfer settings captured at acceptance
    logic [DIV_W-1:0]  r_half;
    logic              r_cpol;
    logic              r_cpha;
    logic [BITS_W-1:0] r_nbits;

    // running counters
    logic [DIV_W-1:0]  r_cnt;
    logic [BITS_W:0]   r_edge_cnt;

    // registered outputs
    logic r_sclk;
    logic r_sample;
    logic r_shift;
    logic r_busy;
    logic r_done;

    // next values
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [BITS_W:0]  w_edge_cnt_nxt;
    logic             w_sclk_nxt;
    logic             w_sample_nxt;
    logic             w_shift_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    // decode helpers
    logic             w_accept;
    logic             w_wrap;
    logic [BITS_W:0]  w_edge_inc;
    logic [BITS_W:0]  w_edge_total;
    logic             w_last_edge;
    logic             w_leading;
    logic             w_is_sample;
    logic [DIV_W-1:0] w_half_in;

    assign w_accept = (r_state == S_IDLE) && start && !abort
                      && (num_bits != '0);

    // a zero divisor would never wrap the counter, so it runs as 1
    assign w_half_in = (div_half == '0) ? H_ONE : div_half;

    assign w_wrap       = (r_cnt == (r_half - H_ONE));
    assign w_edge_inc   = r_edge_cnt + E_ONE;
    assign w_edge_total = {r_nbits, 1'b0};
    assign w_last_edge  = (w_edge_inc == w_edge_total);

    // odd edge numbers are leading edges
    assign w_leading   = w_edge_inc[0];
    assign w_is_sample = w_leading ^ r_cpha;

    // state register
    always_ff @(posedge clk_arr or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_wrap && w_last_edge) begin
                    w_state_nxt = S_GUARD;
                end
            end
            S_GUARD: begin
                if (abort || w_wrap) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // output and counter next-value logic
    always_comb begin
        w_cnt_nxt      = r_cnt;
        w_edge_cnt_nxt = r_edge_cnt;
        w_sclk_nxt     = r_sclk;
        w_sample_nxt   = 1'b0;
        w_shift_nxt    = 1'b0;
        w_busy_nxt     = 1'b0;
        w_done_nxt     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                // track live cpol so the line idles correctly
                w_sclk_nxt     = cpol;
                w_cnt_nxt      = '0;
                w_edge_cnt_nxt = '0;
                w_busy_nxt     = w_accept;
            end
            S_RUN: begin
                if (abort) begin
                    w_sclk_nxt     = r_cpol;
                    w_cnt_nxt      = '0;
                    w_edge_cnt_nxt = '0;
                end else begin
                    w_busy_nxt = 1'b1;
                    if (w_wrap) begin
                        w_cnt_nxt      = '0;
                        w_sclk_nxt     = ~r_sclk;
                        w_edge_cnt_nxt = w_edge_inc;
                        w_sample_nxt   = w_is_sample;
                        w_shift_nxt    = ~w_is_sample;
                    end else begin
                        w_cnt_nxt = r_cnt + H_ONE;
                    end
                end
            end
            S_GUARD: begin
                if (abort) begin
                    w_sclk_nxt     = r_cpol;
                    w_cnt_nxt      = '0;
                    w_edge_cnt_nxt = '0;
                end else if (w_wrap) begin
                    w_cnt_nxt      = '0;
                    w_edge_cnt_nxt = '0;
                    w_done_nxt     = 1'b1;
                end else begin
                    w_busy_nxt = 1'b1;
                    w_cnt_nxt  = r_cnt + H_ONE;
                end
            end
            default: begin
                w_sclk_nxt     = 1'b0;
                w_cnt_nxt      = '0;
                w_edge_cnt_nxt = '0;
            end
        endcase
    end

    // settings latch
    always_ff @(posedge clk_arr or negedge rst_n) begin
        if (!rst_n) begin
            r_half  <= '0;
            r_cpol  <= 1'b0;
            r_cpha  <= 1'b0;
            r_nbits <= '0;
        end else if (w_accept) begin
            r_half  <= w_half_in;
            r_cpol  <= cpol;
            r_cpha  <= cpha;
            r_nbits <= num_bits;
        end
    end

    // counters and output registers
    always_ff @(posedge clk_arr or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_edge_cnt <= '0;
            r_sclk     <= 1'b0;
            r_sample   <= 1'b0;
            r_shift    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_edge_cnt <= w_edge_cnt_nxt;
            r_sclk     <= w_sclk_nxt;
            r_sample   <= w_sample_nxt;
            r_shift    <= w_shift_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign sclk       = r_sclk;
    assign sample_stb = r_sample;
    assign shift_stb  = r_shift;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Directed bench for spi_sclk_gen: expected per-cycle outputs are queued
// from closed-form edge timing and popped one per clock.
module tb_spi_sclk_gen;

    localparam int DIV_W  = 16;
    localparam int BITS_W = 6;

    logic              clk_arr = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [DIV_W-1:0]  div_half = '0;
    logic              cpol = 1'b0;
    logic              cpha = 1'b0;
    logic [BITS_W-1:0] num_bits = '0;
    logic              sclk;
    logic              sample_stb;
    logic              shift_stb;
    logic              busy;
    logic              done;

    // {sclk, sample_stb, shift_stb, busy, done}
    logic [4:0] exp_q[$];
    int n_assert = 0;
    int n_fail = 0;

    spi_sclk_gen #(
        .DIV_W (DIV_W),
        .BITS_W(BITS_W)
    ) dut (
        .clk_arr   (clk_arr),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .div_half  (div_half),
        .cpol      (cpol),
        .cpha      (cpha),
        .num_bits  (num_bits),
        .sclk      (sclk),
        .sample_stb(sample_stb),
        .shift_stb (shift_stb),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk_arr = ~clk_arr;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_arr);
        #1;
    endtask

    task automatic check(input string tag);
        logic [4:0] o;
        logic [4:0] e;
        o = {sclk, sample_stb, shift_stb, busy, done};
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed %b", tag, o);
        end else begin
            e = exp_q.pop_front();
            assert (o === e) else begin
                n_fail++;
                $error("FAIL %s: {sclk,smp,shf,busy,done} observed %b expected %b",
                       tag, o, e);
            end
        end
    endtask

    task automatic push_idle(input logic pol, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({pol, 4'b0000});
        end
    endtask

    // cycle c = c-th clock edge after the accepting edge
    task automatic push_xfer(input logic pol, input logic ph,
                             input int h, input int n);
        int   last;
        int   k;
        int   t;
        logic ev;
        logic lead;
        last = (2 * n + 1) * h;
        for (int c = 0; c <= last; c++) begin
            k    = c / h;
            t    = (k > 2 * n) ? 2 * n : k;
            ev   = (c > 0) && (c % h == 0) && (k <= 2 * n);
            lead = k[0];
            exp_q.push_back({pol ^ t[0],
                             ev && (lead != ph),
                             ev && (lead == ph),
                             c < last,
                             c == last});
        end
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) begin
            tick();
            check(tag);
        end
    endtask

    initial begin
        // reset
        #12;
        push_idle(1'b0, 1);
        check("reset");
        rst_n = 1'b1;
        push_idle(1'b0, 1);
        tick();
        check("idle0");

        // 1: mode 0, H=2, N=8
        cpol = 1'b0; cpha = 1'b0; div_half = 16'd2; num_bits = 6'd8;
        start = 1'b1;
        push_xfer(1'b0, 1'b0, 2, 8);
        tick();
        start = 1'b0;
        check("t1");
        drain("t1");

        // idle follows live cpol
        cpol = 1'b1;
        push_idle(1'b1, 2);
        drain("idle_cpol");

        // 2: mode 3, H=3, N=4
        cpha = 1'b1; div_half = 16'd3; num_bits = 6'd4;
        start = 1'b1;
        push_xfer(1'b1, 1'b1, 3, 4);
        tick();
        start = 1'b0;
        check("t2");
        drain("t2");

        // 3: mode 1, div_half=0 -> H=1, N=1
        cpol = 1'b0; cpha = 1'b1; div_half = 16'd0; num_bits = 6'd1;
        start = 1'b1;
        push_xfer(1'b0, 1'b1, 1, 1);
        tick();
        start = 1'b0;
        check("t3");
        drain("t3");

        // 3b: num_bits=0 ignored
        num_bits = 6'd0;
        start = 1'b1;
        push_idle(1'b0, 3);
        drain("t3_nb0");
        start = 1'b0;

        // abort wins over start in IDLE
        cpha = 1'b0; div_half = 16'd1; num_bits = 6'd4;
        start = 1'b1; abort = 1'b1;
        push_idle(1'b0, 1);
        tick();
        start = 1'b0; abort = 1'b0;
        check("abort_start");
        push_idle(1'b0, 1);
        drain("abort_start");

        // 4a: input changes while busy have no effect
        cpol = 1'b0; cpha = 1'b0; div_half = 16'd2; num_bits = 6'd8;
        start = 1'b1;
        push_xfer(1'b0, 1'b0, 2, 8);
        tick();
        start = 1'b0;
        check("t4a");
        for (int c = 1; c <= 34; c++) begin
            tick();
            check("t4a");
            if (c == 1) begin
                div_half = 16'd5; cpol = 1'b1; cpha = 1'b1;
                num_bits = 6'd3; start = 1'b1;
            end
            if (c == 2) start = 1'b0;
            if (c == 34) begin
                cpol = 1'b0; cpha = 1'b0; div_half = 16'd2;
                num_bits = 6'd8;
            end
        end
        push_idle(1'b0, 1);
        drain("t4a_post");

        // 4b: abort after edge 5
        start = 1'b1;
        push_xfer(1'b0, 1'b0, 2, 8);
        tick();
        start = 1'b0;
        check("t4b");
        for (int c = 1; c <= 10; c++) begin
            tick();
            check("t4b");
            if (c == 3) cpol = 1'b1;
        end
        abort = 1'b1;
        exp_q.delete();
        push_idle(1'b0, 1);
        tick();
        abort = 1'b0;
        check("t4b_abort");
        push_idle(1'b1, 4);
        drain("t4b_post");
        cpol = 1'b0;
        push_idle(1'b0, 1);
        drain("t4b_post");

        // 5: back-to-back with start held through done
        div_half = 16'd2; num_bits = 6'd2;
        start = 1'b1;
        push_xfer(1'b0, 1'b0, 2, 2);
        push_xfer(1'b0, 1'b0, 2, 2);
        tick();
        check("t5");
        for (int c = 1; c <= 21; c++) begin
            tick();
            check("t5");
            if (c == 11) start = 1'b0;
        end
        push_idle(1'b0, 1);
        drain("t5_post");

        // 6: asynchronous reset mid-RUN with sclk high
        num_bits = 6'd8;
        start = 1'b1;
        push_xfer(1'b0, 1'b0, 2, 8);
        tick();
        start = 1'b0;
        check("t6");
        tick();
        check("t6");
        tick();
        check("t6");
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        push_idle(1'b0, 1);
        check("t6_async_rst");
        cpol = 1'b1;
        push_idle(1'b0, 1);
        tick();
        check("t6_in_rst");
        rst_n = 1'b1;
        push_idle(1'b1, 2);
        drain("t6_release");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_sclk_gen.md
Name: spi_sclk_gen

Overview:
Parametrised, fully synchronous SPI serial-clock generator for the SPI master datapath.
- Generates SCLK from the system clock with a programmable half-period of 1..2**DIV_W-1 cycles.
- Supports all four CPOL/CPHA modes.
- Emits exactly 2*num_bits SCLK edges per transfer, with single-cycle sample/shift strobes for the shift register.
- Adds a transfer handshake (start/busy/done) and abort.
- Single clock domain, no derived clocks; SCLK is a registered, glitch-free data output.

Parameters:
DIV_W, 16, width of half-period divisor div_half
BITS_W, 6, width of num_bits (max 2**BITS_W-1 bits per transfer)

Ports:
clk_arr  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request transfer; accepted only in IDLE
abort  in  1  synchronous abort of current transfer
div_half  in  DIV_W  SCLK half-period in clk_arr cycles; 0 treated as 1
cpol  in  1  SCLK idle level
cpha  in  1  0: sample leading/shift trailing; 1: shift leading/sample trailing
num_bits  in  BITS_W  bits per transfer
sclk  out  1  serial clock, registered
sample_stb  out  1  one-cycle pulse, same cycle as sample edge appears on sclk
shift_stb  out  1  one-cycle pulse, same cycle as shift edge appears on sclk
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at normal completion

Behaviour:
Reset (rst_n=0, asynchronous): sclk=0, sample_stb=0, shift_stb=0, busy=0, done=0; state IDLE; all counters 0.

IDLE:
- sclk register loads the live cpol input every cycle (one-cycle lag, no glitch).
- Start is accepted when start=1, abort=0 and num_bits!=0.
- On acceptance: latch div_half (0 becomes 1) as H, latch cpol, cpha, num_bits (N); half-counter=0, edge_cnt=0; go to RUN; busy=1 from next cycle.
- start with num_bits=0 is ignored.

RUN:
- Half-counter increments each cycle.
- When half-counter==H-1: counter clears, sclk toggles, edge_cnt increments.
- The k-th edge (k=1..2N) appears on sclk in the cycle after clock edge k*H counted from the acceptance edge.
- Odd k = leading edge, even k = trailing edge.
- cpha=0: sample_stb on leading, shift_stb on trailing. cpha=1: the reverse.
- Strobes are registered alongside sclk, so a strobe is high exactly in the first cycle of the new sclk level.
- After edge 2N: go to GUARD; sclk is now at latched cpol.

GUARD:
- Waits one more half-period (H cycles).
- Then: busy=0 and done=1 in the same cycle (cycle after edge (2N+1)*H); return to IDLE.
- A start present in the done cycle is accepted.

Inputs while busy:
- start ignored.
- div_half, cpol, cpha, num_bits changes have no effect until next acceptance.

Abort:
- abort=1 in RUN or GUARD: next cycle state IDLE, sclk=latched cpol, busy=0, no strobe, no done.
- This may truncate the current half-period.
- abort and start together in IDLE: abort wins, start ignored.

Width rules:
- Half-counter DIV_W bits; edge_cnt BITS_W+1 bits; no wrap possible at maximum settings.
- div_half=2**DIV_W-1 is legal.

Sclk is always the output of a single flip-flop; no combinational path from inputs to any output.

Test Plan:
1. Mode 0, div_half=2, num_bits=8, start at edge 0 -> 16 sclk edges at cycles 2,4,…,32; sclk period 4; 8 sample_stb on rising, 8 shift_stb on falling; done at cycle 34, busy low same cycle.
2. Mode 3 (cpol=1, cpha=1), div_half=3, num_bits=4 -> idle high; shift_stb on the 4 falling edges, sample_stb on the 4 rising edges; sclk returns high; done at cycle 27.
3. div_half=0, num_bits=1, mode 1 -> treated as H=1: edges at cycles 1,2; shift_stb then sample_stb; done at cycle 3. Repeat with num_bits=0 -> busy never asserts.
4. Mid-transfer: pulse start, change div_half/cpol/num_bits while busy -> no effect on edge count or timing. Assert abort after edge 5 -> sclk=cpol next cycle, busy=0, no done, no further strobes.
5. Back-to-back: hold start high through done cycle -> second transfer accepted in done cycle; no extra or missing sclk edge between transfers.
6. Reset mid-RUN with sclk high -> all outputs 0 immediately (asynchronous). After release in IDLE with cpol=1, sclk goes high one cycle later.
